multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle LEGv8 datapath; sits directly upstream of ALU_control.
- Per step, drives ALUOp[1:0] plus every datapath enable/mux select, sequencing fetch, decode, execute, memory and writeback.
- Supports R-type ADD/SUB/AND/ORR, LDUR, STUR, CBZ and B.
- Stalls on a memory ready handshake; traps unsupported opcodes and memory timeouts in a sticky fault state.

Parameters:
- OPC_W, 11, instruction opcode field width (IR[31:21]).
- MEM_TIMEOUT, 15, max stall cycles waiting on mem_ready before fault; counter width is $clog2(MEM_TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  OPC_W  IR[31:21], valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- ALUOp  output  2  00 add, 01 pass-B/zero test, 10 use opcode field.
- ALUSrcA  output  1  0 PC, 1 register A.
- ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext D-offset, 11 branch offset<<2.
- IorD  output  1  0 PC address, 1 ALUOut address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  latch instruction register.
- PCWrite  output  1  unconditional PC update.
- PCWriteCond  output  1  PC update if ALU Zero.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- RegWrite  output  1  register file write enable.
- MemtoReg  output  1  writeback select: 1 MDR, 0 ALUOut.
- Reg2Loc  output  1  read reg2 from Rt (1) vs Rm (0).
- fault  output  1  sticky: illegal opcode or memory timeout.
- state_o  output  4  current state encoding, for debug/bench.

Behaviour:
- Reset: async on rst_n low. State goes to FETCH, stall counter clears to 0, fault clears to 0. All outputs read 0 while rst_n is low. The first FETCH outputs appear in the cycle after rst_n deasserts.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_COMPLETE=7, BRANCH=8, JUMP=9, FAULT=10.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (the only Mealy outputs).
  - mem_ready=1 goes to DECODE; otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Reg2Loc=1 if opcode is STUR or CBZ.
  - Opcode dispatch:
    - R-type (10001011000 / 11001011000 / 10001010000 / 10101010000) goes to EXECUTE.
    - LDUR 11111000010 and STUR 11111000000 go to MEM_ADDR.
    - CBZ (opcode[10:3]=10110100) goes to BRANCH.
    - B (opcode[10:5]=000101) goes to JUMP.
    - Any other opcode goes to FAULT.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LDUR goes to MEM_READ, STUR goes to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. mem_ready=1 goes to MEM_WB; otherwise stay.
- MEM_WB: RegWrite=1, MemtoReg=1, then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, Reg2Loc=1. mem_ready=1 goes to FETCH; otherwise stay.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then R_COMPLETE.
- R_COMPLETE: RegWrite=1, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- FAULT: fault=1 and all other outputs 0. Terminal until reset.
- Instruction latency: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles, with zero memory wait. Each wait cycle adds 1.
- Stall counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0.
  - Clears on mem_ready=1 or on leaving the state.
  - If the count reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT; mem_ready in the same cycle wins.
  - The counter saturates and does not wrap.
- opcode is ignored outside DECODE/MEM_ADDR; X on opcode in other states must not affect outputs.
- Reset asserted mid-instruction aborts immediately, with no partial register or memory write after the reset edge.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - the state enum (4-bit);
  - the opcode constants for ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B, with their match masks;
  - the ALUOp encodings ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_RTYPE=10;
  - the ALUSrcB and PCSource select encodings.
- One sub-module, opcode_classify: a combinational opcode-to-class decoder with outputs is_rtype, is_ldur, is_stur, is_cbz, is_b, is_illegal. The FSM instantiates it once.

Test Plan:
- ADD (10001011000), mem_ready tied 1 -> state_o sequence 0,1,6,7,0; ALUOp=10 in EXECUTE; RegWrite=1 only in R_COMPLETE; ALU_control then yields ALUCtl=0010.
- LDUR (11111000010), mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles; MemRead=1, IorD=1 throughout; then MEM_WB with RegWrite=1, MemtoReg=1.
- STUR then CBZ back-to-back -> MemWrite=1 for exactly one ready cycle. CBZ gives BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01, Reg2Loc=1. RegWrite stays 0 for both instructions.
- Opcode 11111111111 at DECODE -> FAULT next cycle; fault=1 and stays 1 for 20 cycles of arbitrary input; rst_n pulse returns to FETCH with fault=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT entered after exactly 15 stall cycles. A repeat run with mem_ready=1 on the 15th stall cycle goes to DECODE instead.
- rst_n asserted asynchronously mid-MEM_WRITE -> MemWrite drops to 0 without waiting for a clock edge; after release, state_o=0 and IRWrite follows mem_ready.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : legv8_ctrl_pkg
// Purpose  : Shared state type, opcode patterns and datapath select encodings
//            for the LEGv8 multicycle main control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package legv8_ctrl_pkg;

    localparam int OPC_WIDTH = 11;

    typedef logic [OPC_WIDTH-1:0] opc_t;

    // Encodings are architecturally visible on state_o, so they are pinned.
    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_ADDR   = 4'd2,
        S_MEM_READ   = 4'd3,
        S_MEM_WB     = 4'd4,
        S_MEM_WRITE  = 4'd5,
        S_EXECUTE    = 4'd6,
        S_R_COMPLETE = 4'd7,
        S_BRANCH     = 4'd8,
        S_JUMP       = 4'd9,
        S_FAULT      = 4'd10
    } state_t;

    // Opcode patterns and the bits of IR[31:21] each one actually decodes.
    localparam opc_t c_mask_full = 11'b111_1111_1111;
    localparam opc_t c_mask_cbz  = 11'b111_1111_1000;
    localparam opc_t c_mask_b    = 11'b111_1110_0000;

    localparam opc_t c_opc_add   = 11'b100_0101_1000;
    localparam opc_t c_opc_sub   = 11'b110_0101_1000;
    localparam opc_t c_opc_and   = 11'b100_0101_0000;
    localparam opc_t c_opc_orr   = 11'b101_0101_0000;
    localparam opc_t c_opc_ldur  = 11'b111_1100_0010;
    localparam opc_t c_opc_stur  = 11'b111_1100_0000;
    localparam opc_t c_opc_cbz   = 11'b101_1010_0000;
    localparam opc_t c_opc_b     = 11'b000_1010_0000;

    // ALUOp encodings consumed by ALU_control.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // ALU B-operand mux selects.
    localparam logic [1:0] c_srcb_reg  = 2'b00;
    localparam logic [1:0] c_srcb_four = 2'b01;
    localparam logic [1:0] c_srcb_doff = 2'b10;
    localparam logic [1:0] c_srcb_boff = 2'b11;

    // PC source mux selects.
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // True when the masked opcode bits equal the masked pattern.
    function automatic logic opc_match(input opc_t opc, input opc_t value, input opc_t mask);
        return ((opc & mask) == (value & mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_classify.sv
`default_nettype none
// ============================================================================
// Module   : opcode_classify
// Purpose  : Combinational decoder from IR[31:21] to the instruction classes
//            the main control FSM dispatches on.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_classify #(
    parameter int OPC_W = legv8_ctrl_pkg::OPC_WIDTH
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             is_rtype,
    output logic             is_ldur,
    output logic             is_stur,
    output logic             is_cbz,
    output logic             is_b,
    output logic             is_illegal
);
    import legv8_ctrl_pkg::*;

    // Exactly one class is asserted for any opcode; anything unmatched is illegal.
    always_comb begin
        is_rtype   = opc_match(opcode, c_opc_add, c_mask_full)
                   | opc_match(opcode, c_opc_sub, c_mask_full)
                   | opc_match(opcode, c_opc_and, c_mask_full)
                   | opc_match(opcode, c_opc_orr, c_mask_full);
        is_ldur    = opc_match(opcode, c_opc_ldur, c_mask_full);
        is_stur    = opc_match(opcode, c_opc_stur, c_mask_full);
        is_cbz     = opc_match(opcode, c_opc_cbz, c_mask_cbz);
        is_b       = opc_match(opcode, c_opc_b, c_mask_b);
        is_illegal = ~(is_rtype | is_ldur | is_stur | is_cbz | is_b);
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore main control FSM for the multicycle LEGv8 datapath. Walks
//            fetch/decode/execute/memory/writeback, stalls on mem_ready and
//            traps illegal opcodes or memory timeouts in a sticky FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int OPC_W       = legv8_ctrl_pkg::OPC_WIDTH,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             Reg2Loc,
    output logic             fault,
    output logic [3:0]       state_o
);
    import legv8_ctrl_pkg::*;

    localparam int                    c_stall_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_stall_w-1:0]  c_stall_max  = c_stall_w'(MEM_TIMEOUT);
    localparam logic [c_stall_w-1:0]  c_stall_last = c_stall_w'(MEM_TIMEOUT - 1);
    localparam logic [c_stall_w-1:0]  c_stall_one  = c_stall_w'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_stall_w-1:0] r_stall;

    logic w_is_rtype;
    logic w_is_ldur;
    logic w_is_stur;
    logic w_is_cbz;
    logic w_is_b;
    logic w_is_illegal;
    logic w_in_wait;
    logic w_timeout;

    opcode_classify #(
        .OPC_W (OPC_W)
    ) u_classify (
        .opcode     (opcode),
        .is_rtype   (w_is_rtype),
        .is_ldur    (w_is_ldur),
        .is_stur    (w_is_stur),
        .is_cbz     (w_is_cbz),
        .is_b       (w_is_b),
        .is_illegal (w_is_illegal)
    );

    // The three states that wait on the memory handshake share one stall counter.
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    // The cycle that would bring the count up to MEM_TIMEOUT without ready is the timeout.
    assign w_timeout = w_in_wait && !mem_ready && (r_stall >= c_stall_last);

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Stall counter: counts unready wait cycles, saturates, clears on ready or state exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_in_wait && !mem_ready && !w_timeout) begin
            if (r_stall != c_stall_max) begin
                r_stall <= r_stall + c_stall_one;
            end
        end else begin
            r_stall <= '0;
        end
    end

    // Next-state selection; opcode is only consulted in DECODE and MEM_ADDR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next_state = S_DECODE;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_DECODE: begin
                if (w_is_illegal)               w_next_state = S_FAULT;
                else if (w_is_rtype)            w_next_state = S_EXECUTE;
                else if (w_is_ldur || w_is_stur) w_next_state = S_MEM_ADDR;
                else if (w_is_cbz)              w_next_state = S_BRANCH;
                else if (w_is_b)                w_next_state = S_JUMP;
                else                            w_next_state = S_FAULT;
            end
            S_MEM_ADDR: begin
                if (w_is_ldur)      w_next_state = S_MEM_READ;
                else if (w_is_stur) w_next_state = S_MEM_WRITE;
                else                w_next_state = S_FAULT;
            end
            S_MEM_READ: begin
                if (mem_ready)      w_next_state = S_MEM_WB;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_MEM_WRITE: begin
                if (mem_ready)      w_next_state = S_FETCH;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_MEM_WB:     w_next_state = S_FETCH;
            S_EXECUTE:    w_next_state = S_R_COMPLETE;
            S_R_COMPLETE: w_next_state = S_FETCH;
            S_BRANCH:     w_next_state = S_FETCH;
            S_JUMP:       w_next_state = S_FETCH;
            S_FAULT:      w_next_state = S_FAULT;
            default:      w_next_state = S_FAULT;
        endcase
    end

    // Datapath controls per state; everything is forced low while rst_n is low.
    always_comb begin
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = c_srcb_reg;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = c_pcsrc_alu;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        Reg2Loc     = 1'b0;
        fault       = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = c_srcb_four;
                    // Latch IR and advance PC only on the cycle memory delivers.
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = c_srcb_boff;
                    Reg2Loc = w_is_stur | w_is_cbz;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = c_srcb_doff;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_RTYPE;
                end
                S_R_COMPLETE: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_PASSB;
                    Reg2Loc     = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = c_pcsrc_aluout;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = c_pcsrc_jump;
                end
                S_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    fault = 1'b0;
                end
            endcase
        end
    end

    assign state_o = rst_n ? r_state : S_FETCH;

endmodule
`default_nettype wire
